// File: rtl/rv_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_isa_pkg
// Brief    : RV32I opcodes, field-bundle kinds and immediate limits for the encoder
// Revision : 1.0
// ============================================================================
package rv_isa_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        KIND_R      = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_STORE  = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JAL    = 3'd4,
        KIND_OPIMM  = 3'd5
    } kind_e;

    localparam logic signed [20:0] IMM12_MIN = -21'sd2048;
    localparam logic signed [20:0] IMM12_MAX =  21'sd2047;
    localparam logic signed [20:0] IMM13_MIN = -21'sd4096;
    localparam logic signed [20:0] IMM13_MAX =  21'sd4095;

    function automatic logic imm_in_range(input logic [20:0] imm,
                                          input logic signed [20:0] lo,
                                          input logic signed [20:0] hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_encoder_if
// Brief    : field-bundle input, IMEM write port and session status of the encoder
// Revision : 1.0
// ============================================================================
interface rv_instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        in_kind;
    logic [2:0]        in_funct3;
    logic              in_funct7_5;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [20:0]       in_imm;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;

    // Loader / bench side
    modport master (
        output start, in_valid, in_last, in_kind, in_funct3, in_funct7_5,
               in_rd, in_rs1, in_rs2, in_imm, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    // Encoder side
    modport slave (
        input  start, in_valid, in_last, in_kind, in_funct3, in_funct7_5,
               in_rd, in_rs1, in_rs2, in_imm, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/rv_imm_pack.sv
`default_nettype none
// ============================================================================
// Module   : rv_imm_pack
// Brief    : combinational RV32I word packer with range/alignment error flag;
//            RV_ENC_OPIMM_EN enables kind 5 (OP-IMM)
// Revision : 1.0
// ============================================================================
module rv_imm_pack
    import rv_isa_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [20:0] imm_i,
    output logic [31:0] word_o,
    output logic        err_o
);

    always_comb begin
        word_o = NOP;
        err_o  = 1'b0;
        case (kind_i)
            KIND_R: begin
                word_o = {1'b0, funct7_5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            end
            KIND_LOAD: begin
                word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
                err_o  = !imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
            end
            KIND_STORE: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
                err_o  = !imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
            end
            KIND_BRANCH: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], OP_BRANCH};
                err_o  = !imm_in_range(imm_i, IMM13_MIN, IMM13_MAX) | imm_i[0];
            end
            KIND_JAL: begin
                // 21-bit imm already spans the full JAL range; only alignment can fail
                word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                err_o  = imm_i[0];
            end
`ifdef RV_ENC_OPIMM_EN
            KIND_OPIMM: begin
                if (funct3_i == 3'b101)
                    word_o = {1'b0, funct7_5_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_OPIMM};
                else
                    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_OPIMM};
            end
`else
            KIND_OPIMM: begin
                err_o = 1'b1;
            end
`endif
            default: begin
                err_o = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_encoder
// Brief    : load-session FSM streaming encoded RV32I words into IMEM
//            (RV_ENC_OPIMM_EN adds OP-IMM encoding in rv_imm_pack)
// Revision : 1.0
// ============================================================================
module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    rv_instr_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);

    state_e            state_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       enc_word;
    logic              enc_err;
    logic              in_ready;
    logic              accept;
    logic              wr_fire;

    rv_imm_pack u_pack (
        .kind_i     (bus.in_kind),
        .funct3_i   (bus.in_funct3),
        .funct7_5_i (bus.in_funct7_5),
        .rd_i       (bus.in_rd),
        .rs1_i      (bus.in_rs1),
        .rs2_i      (bus.in_rs2),
        .imm_i      (bus.in_imm),
        .word_o     (enc_word),
        .err_o      (enc_err)
    );

    assign wr_fire  = wr_en_q & bus.wr_ready;
    assign in_ready = (state_q == ST_RUN) & (~wr_en_q | bus.wr_ready);
    assign accept   = bus.in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
            addr_q  <= START_ADDR;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_fire) begin
                wr_en_q <= 1'b0;
                addr_q  <= addr_q + ADDR_STEP;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        addr_q  <= START_ADDR;
                        err_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A new accept may coincide with the retiring write; the new word wins
                    if (accept) begin
                        wr_en_q <= 1'b1;
                        data_q  <= enc_word;
                        if (enc_err)
                            err_q <= 1'b1;
                        if (bus.in_last)
                            state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wr_fire) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_instr_encoder
// Brief    : directed + randomized bench with an arithmetic RV32I reference model
// Revision : 1.0
// ============================================================================
module tb_rv_instr_encoder;

    localparam int ADDR_W    = 10;
    localparam int BASE_ADDR = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   n_cmp      = 0;
    int   n_bad      = 0;
    exp_t sb[$];
    int   exp_addr   = BASE_ADDR;
    bit   exp_err    = 1'b0;
    int   exp_done   = 0;
    int   done_cnt   = 0;
    int   ready_mode = 0;
    int   last_wait  = 0;

    always #5 clk = ~clk;

    rv_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    rv_instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder: immediates handled as plain signed integers
    function automatic void ref_encode(input int kind, input int f3, input int f7,
                                       input int rd, input int rs1, input int rs2,
                                       input int imm, output logic [31:0] w, output bit e);
        int regs;
        regs = (rs1 << 15) | (f3 << 12);
        e = 1'b0;
        case (kind)
            0: w = (f7 << 30) | (rs2 << 20) | regs | (rd << 7) | 'h33;
            1: begin
                w = ((imm & 'hFFF) << 20) | regs | (rd << 7) | 'h03;
                e = (imm < -2048) || (imm > 2047);
            end
            2: begin
                w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | regs | ((imm & 'h1F) << 7) | 'h23;
                e = (imm < -2048) || (imm > 2047);
            end
            3: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) | regs
                  | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
                e = (imm < -4096) || (imm > 4095) || ((imm & 1) != 0);
            end
            4: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
                e = ((imm & 1) != 0);
            end
`ifdef RV_ENC_OPIMM_EN
            5: begin
                if (f3 == 5) w = (f7 << 30) | ((imm & 'h1F) << 20) | regs | (rd << 7) | 'h13;
                else         w = ((imm & 'hFFF) << 20) | regs | (rd << 7) | 'h13;
            end
`endif
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
    endfunction

    function automatic int rand_imm(input int kind);
        int v;
        if ($urandom_range(0, 7) == 0) begin
            v = int'($urandom_range(0, 2097151));
            if (v >= 1048576) v = v - 2097152;
        end else if (kind == 3) begin
            v = int'($urandom_range(0, 4095));
            v = (v - 2048) * 2;
        end else if (kind == 4) begin
            v = int'($urandom_range(0, 1048575));
            v = (v - 524288) * 2;
        end else begin
            v = int'($urandom_range(0, 4095));
            v = v - 2048;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_addr = BASE_ADDR;
        exp_err  = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("err_cleared_by_start", 32'(bus.err), 32'd0);
    endtask

    task automatic send(input int kind, input int f3, input int f7, input int rd,
                        input int rs1, input int rs2, input int imm, input bit last,
                        input bit has_exp, input logic [31:0] exp_w, input int gap);
        logic [31:0] w;
        bit          e;
        int          t;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_kind     = 3'(kind);
        bus.in_funct3   = 3'(f3);
        bus.in_funct7_5 = 1'(f7);
        bus.in_rd       = 5'(rd);
        bus.in_rs1      = 5'(rs1);
        bus.in_rs2      = 5'(rs2);
        bus.in_imm      = 21'(imm);
        bus.in_last     = last;
        bus.in_valid    = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        last_wait = t;
        if (!bus.in_ready) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        ref_encode(kind, f3, f7, rd, rs1, rs2, imm, w, e);
        if (has_exp) w = exp_w;
        sb.push_back('{addr: 32'(exp_addr), data: w});
        exp_addr = (exp_addr + 4) % (1 << ADDR_W);
        exp_err  = exp_err | e;
        if (last) exp_done++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("latency1_wr_en", 32'(bus.wr_en), 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 1000) begin
            t++;
            @(negedge clk);
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("err_flag", 32'(bus.err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    // Write-port monitor: every cycle with wr_en must present the oldest expected word
    always @(negedge clk) begin
        if (rst && bus.wr_en) begin
            if (sb.size() == 0) begin
                check("write_without_accept", 32'(bus.wr_en), 32'd0);
            end else begin
                check("wr_addr", 32'(bus.wr_addr), sb[0].addr);
                check("wr_data", bus.wr_data, sb[0].data);
                if (bus.wr_ready) void'(sb.pop_front());
            end
        end
        if (bus.done) done_cnt++;
    end

    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.wr_ready = 1'b1;
                1:       bus.wr_ready = ($urandom_range(0, 3) != 0);
                default: bus.wr_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        bus.start       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_last     = 1'b0;
        bus.in_kind     = '0;
        bus.in_funct3   = '0;
        bus.in_funct7_5 = 1'b0;
        bus.in_rd       = '0;
        bus.in_rs1      = '0;
        bus.in_rs2      = '0;
        bus.in_imm      = '0;

        #12;
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'(BASE_ADDR));
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // add x3, x1, x2
        do_start();
        send(0, 0, 0, 3, 1, 2, 0, 1'b1, 1'b1, 32'h002081B3, 0);
        wait_idle();

        // lw x5, 8(x2) ; sw x6, 12(x2) back-to-back
        do_start();
        send(1, 2, 0, 5, 2, 0, 8, 1'b0, 1'b1, 32'h00812283, 0);
        send(2, 2, 0, 0, 2, 6, 12, 1'b1, 1'b1, 32'h00612623, 0);
        check("back_to_back_wait", 32'(last_wait), 32'd0);
        wait_idle();

        // beq x1, x2, -8 ; jal x1, 16
        do_start();
        send(3, 0, 0, 0, 1, 2, -8, 1'b0, 1'b1, 32'hFE208CE3, 0);
        send(4, 0, 0, 1, 0, 0, 16, 1'b1, 1'b1, 32'h010000EF, 0);
        wait_idle();

        // IMEM back-pressure with a pending write
        do_start();
        ready_mode = 2;
        send(0, 0, 1, 9, 4, 5, 0, 1'b0, 1'b0, 32'd0, 0);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_wr_en", 32'(bus.wr_en), 32'd1);
        end
        ready_mode = 0;
        send(0, 7, 0, 10, 11, 12, 0, 1'b1, 1'b0, 32'd0, 0);
        wait_idle();

        // undefined kind and misaligned branch
        do_start();
        send(6, 3, 1, 7, 8, 9, 100, 1'b0, 1'b1, 32'h00000013, 0);
        send(3, 0, 0, 0, 1, 2, 5, 1'b1, 1'b0, 32'd0, 0);
        wait_idle();
        repeat (3) tick();
        check("err_sticky_hold", 32'(bus.err), 32'd1);
        do_start();
        send(0, 0, 0, 1, 2, 3, 0, 1'b1, 1'b0, 32'd0, 0);
        wait_idle();

        // asynchronous reset with a write still pending
        do_start();
        send(0, 0, 0, 1, 1, 1, 0, 1'b0, 1'b0, 32'd0, 0);
        send(0, 0, 0, 2, 2, 2, 0, 1'b0, 1'b0, 32'd0, 0);
        send(0, 0, 0, 3, 3, 3, 0, 1'b0, 1'b0, 32'd0, 0);
        #1;
        rst = 1'b0;
        #1;
        check("abort_wr_en", 32'(bus.wr_en), 32'd0);
        check("abort_wr_addr", 32'(bus.wr_addr), 32'(BASE_ADDR));
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        do_start();
        send(0, 0, 1, 7, 3, 4, 0, 1'b1, 1'b0, 32'd0, 0);
        wait_idle();

        // randomized sessions with random back-pressure and ignored start pulses
        ready_mode = 1;
        for (int s = 0; s < 8; s++) begin
            do_start();
            n = int'($urandom_range(3, 14));
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 5) == 0) begin
                    bus.start = 1'b1;
                    tick();
                    bus.start = 1'b0;
                    check("start_ignored_busy", 32'(bus.busy), 32'd1);
                end
                k = int'($urandom_range(0, 7));
                send(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), rand_imm(k), (i == n - 1),
                     1'b0, 32'd0, int'($urandom_range(0, 2)));
            end
            wait_idle();
        end

        // long session wrapping the address counter
        ready_mode = 0;
        do_start();
        for (int i = 0; i < 260; i++) begin
            send(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), 0, (i == 259), 1'b0, 32'd0, 0);
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
